// File: rtl/fifo_flex_if.sv
// Handshake bundle for fifo_flex: producer/consumer controls plus status.
// master drives requests and data in; slave is the FIFO itself.
interface fifo_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush,
    output wr_en,
    output din,
    output rd_en,
    input  dout,
    input  dout_valid,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  level,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  flush,
    input  wr_en,
    input  din,
    input  rd_en,
    output dout,
    output dout_valid,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output level,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/fifo_flex.sv
// Synchronous FIFO with show-ahead or registered read, level output,
// programmable almost thresholds, flush and sticky error flags.
module fifo_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter bit FWFT          = 1'b1,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input logic        clk,
  input logic        rst,
  fifo_flex_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] LVL_MAX =
    LW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL =
    LW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL =
    LW'(AEMPTY_THRESH);

  if (AEMPTY_THRESH < 0 ||
      AEMPTY_THRESH >= AFULL_THRESH ||
      AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("fifo_flex: illegal threshold setting");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic                  ovf_q;
  logic                  udf_q;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;
  logic wr_err;
  logic rd_err;

  // All status is derived from the registered level only,
  // so it can never move between clock edges.
  assign full   = (level_q == LVL_MAX);
  assign empty  = (level_q == '0);

  assign wr_acc = bus.wr_en & ~full  & ~bus.flush;
  assign rd_acc = bus.rd_en & ~empty & ~bus.flush;
  assign wr_err = bus.wr_en &  full  & ~bus.flush;
  assign rd_err = bus.rd_en &  empty & ~bus.flush;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        (wr_acc && !rd_acc): level_q <= level_q + 1'b1;
        (rd_acc && !wr_acc): level_q <= level_q - 1'b1;
        default:             level_q <= level_q;
      endcase
      if (wr_err) begin
        ovf_q <= 1'b1;
      end
      if (rd_err) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.level        = level_q;
  assign bus.almost_full  = (level_q >= AF_LVL);
  assign bus.almost_empty = (level_q <= AE_LVL);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  if (FWFT) begin : g_fwft
    assign bus.dout       = mem[rd_ptr];
    assign bus.dout_valid = ~empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  vld_q;

    // dout deliberately survives flush; only the valid strobe clears.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= mem[rd_ptr];
        end
      end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = vld_q;
  end

  a_no_both: assert property (
    @(posedge clk) disable iff (rst)
    !(full && empty));

  a_lvl_max: assert property (
    @(posedge clk) disable iff (rst)
    level_q <= LVL_MAX);

  a_ptr_gap: assert property (
    @(posedge clk) disable iff (rst)
    ADDR_WIDTH'(level_q) == ADDR_WIDTH'(wr_ptr - rd_ptr));

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: one show-ahead and one registered
// instance, checked against hand-computed values.
module tb_fifo_flex;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) a_if ();
  fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b_if ();

  fifo_flex #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b1)
  ) u_fwft (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );

  fifo_flex #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b0)
  ) u_reg (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_if.flush = 1'b0; a_if.wr_en = 1'b0;
    a_if.rd_en = 1'b0; a_if.din   = '0;
    b_if.flush = 1'b0; b_if.wr_en = 1'b0;
    b_if.rd_en = 1'b0; b_if.din   = '0;

    #12;
    check("rst_level", 32'(a_if.level), 32'd0);
    check("rst_empty", 32'(a_if.empty), 32'd1);
    check("rst_full", 32'(a_if.full), 32'd0);
    check("rst_aempty", 32'(a_if.almost_empty), 32'd1);
    check("rst_afull", 32'(a_if.almost_full), 32'd0);
    check("rst_valid", 32'(a_if.dout_valid), 32'd0);
    check("rst_ovf", 32'(a_if.overflow), 32'd0);
    check("rst_udf", 32'(a_if.underflow), 32'd0);
    check("rst_b_dout", 32'(b_if.dout), 32'd0);
    check("rst_b_valid", 32'(b_if.dout_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      a_if.wr_en = 1'b1;
      a_if.din   = 8'(i);
      tick();
      check("fill_level", 32'(a_if.level), 32'(i));
      check("fill_afull", 32'(a_if.almost_full), 32'(i >= 14));
      check("fill_full", 32'(a_if.full), 32'(i == 16));
    end
    a_if.din = 8'hEE;
    tick();
    a_if.wr_en = 1'b0;
    check("ovf_set", 32'(a_if.overflow), 32'd1);
    check("ovf_level", 32'(a_if.level), 32'd16);

    // drain in order
    for (int i = 1; i <= 16; i++) begin
      check("drain_dout", 32'(a_if.dout), 32'(i));
      check("drain_valid", 32'(a_if.dout_valid), 32'd1);
      a_if.rd_en = 1'b1;
      tick();
      check("drain_aempty", 32'(a_if.almost_empty),
            32'((16 - i) <= 2));
    end
    check("drain_empty", 32'(a_if.empty), 32'd1);
    check("drain_valid0", 32'(a_if.dout_valid), 32'd0);
    tick();
    a_if.rd_en = 1'b0;
    check("udf_set", 32'(a_if.underflow), 32'd1);
    check("udf_level", 32'(a_if.level), 32'd0);

    // flush with 5 words, overflow set, and a write pending
    for (int i = 0; i < 5; i++) begin
      a_if.wr_en = 1'b1;
      a_if.din   = 8'(8'h30 + i);
      tick();
    end
    check("pre_flush_lvl", 32'(a_if.level), 32'd5);
    a_if.flush = 1'b1;
    a_if.din   = 8'hEE;
    tick();
    a_if.flush = 1'b0;
    a_if.wr_en = 1'b0;
    check("flush_level", 32'(a_if.level), 32'd0);
    check("flush_empty", 32'(a_if.empty), 32'd1);
    check("flush_ovf", 32'(a_if.overflow), 32'd0);
    check("flush_udf", 32'(a_if.underflow), 32'd0);
    check("flush_valid", 32'(a_if.dout_valid), 32'd0);
    a_if.wr_en = 1'b1;
    a_if.din   = 8'h55;
    tick();
    a_if.wr_en = 1'b0;
    check("post_flush_lvl", 32'(a_if.level), 32'd1);
    check("post_flush_dout", 32'(a_if.dout), 32'h55);
    a_if.rd_en = 1'b1;
    tick();
    a_if.rd_en = 1'b0;

    // prefill 15, then 40 cycles of simultaneous read+write
    for (int i = 0; i < 15; i++) begin
      a_if.wr_en = 1'b1;
      a_if.din   = 8'(i);
      tick();
    end
    check("pre_wrap_lvl", 32'(a_if.level), 32'd15);
    for (int c = 0; c < 40; c++) begin
      a_if.wr_en = 1'b1;
      a_if.rd_en = 1'b1;
      a_if.din   = 8'(15 + c);
      check("wrap_dout", 32'(a_if.dout), 32'(c));
      tick();
      check("wrap_level", 32'(a_if.level), 32'd15);
    end
    a_if.rd_en = 1'b0;
    a_if.din   = 8'd55;
    tick();
    check("wrap_full", 32'(a_if.full), 32'd1);
    a_if.rd_en = 1'b1;
    a_if.din   = 8'hFF;
    tick();
    a_if.wr_en = 1'b0;
    check("full_both_lvl", 32'(a_if.level), 32'd15);
    check("full_both_ovf", 32'(a_if.overflow), 32'd1);
    for (int i = 41; i <= 55; i++) begin
      check("tail_dout", 32'(a_if.dout), 32'(i));
      tick();
    end
    a_if.rd_en = 1'b0;
    check("tail_empty", 32'(a_if.empty), 32'd1);

    // registered read path
    b_if.wr_en = 1'b1;
    b_if.din   = 8'hA5;
    tick();
    b_if.wr_en = 1'b0;
    check("reg_lvl", 32'(b_if.level), 32'd1);
    check("reg_nvalid", 32'(b_if.dout_valid), 32'd0);
    b_if.rd_en = 1'b1;
    tick();
    b_if.rd_en = 1'b0;
    check("reg_dout", 32'(b_if.dout), 32'hA5);
    check("reg_valid", 32'(b_if.dout_valid), 32'd1);
    tick();
    check("reg_hold", 32'(b_if.dout), 32'hA5);
    check("reg_valid0", 32'(b_if.dout_valid), 32'd0);
    check("reg_empty", 32'(b_if.empty), 32'd1);

    // asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) begin
      a_if.wr_en = 1'b1;
      a_if.din   = 8'(8'h70 + i);
      tick();
    end
    check("burst_lvl", 32'(a_if.level), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_level", 32'(a_if.level), 32'd0);
    check("arst_empty", 32'(a_if.empty), 32'd1);
    check("arst_valid", 32'(a_if.dout_valid), 32'd0);
    tick();
    check("arst_hold", 32'(a_if.level), 32'd0);
    a_if.wr_en = 1'b0;
    rst = 1'b0;
    tick();
    a_if.wr_en = 1'b1;
    a_if.din   = 8'h99;
    tick();
    a_if.wr_en = 1'b0;
    check("arst_new_lvl", 32'(a_if.level), 32'd1);
    check("arst_new_dout", 32'(a_if.dout), 32'h99);
    check("arst_new_ovf", 32'(a_if.overflow), 32'd0);
    a_if.rd_en = 1'b1;
    tick();
    a_if.rd_en = 1'b0;
    check("arst_drain", 32'(a_if.empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
